// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM with post-reset clear.
package ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 2;

    // Wide enough for any practical word; zero-extension leaves the XOR unchanged.
    localparam int PARITY_MAX_W = 1024;

    function automatic logic parity_f(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Optional extra output register stage for the read path (READ_LATENCY 1 or 2).
// Carries rd_perr alongside the data when RAM_PARITY_EN is defined.
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
`ifdef RAM_PARITY_EN
    input  logic                  in_perr,
    output logic                  out_perr,
`endif
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    generate
        if (READ_LATENCY >= RD_LAT_MAX) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
`ifdef RAM_PARITY_EN
                    out_perr  <= 1'b0;
`endif
                end else begin
                    out_valid <= in_valid;
                    // Data holds between valid pulses.
                    if (in_valid) begin
                        out_data <= in_data;
                    end
`ifdef RAM_PARITY_EN
                    out_perr  <= in_valid & in_perr;
`endif
                end
            end
        end else begin : g_bypass
            logic unused_pipe;
            assign unused_pipe = clk ^ rst;
            assign out_data    = in_data;
            assign out_valid   = in_valid;
`ifdef RAM_PARITY_EN
            assign out_perr    = in_perr;
`endif
        end
    endgenerate

endmodule

// File: rtl/ram_sdp_sr_rw_init.sv
// Simple dual-port RAM, read-first, with a hardware clear sweep after every reset.
// Define RAM_PARITY_EN to store an even-parity bit per word and expose rd_perr.
//
// state | meaning
// INIT  | clearing mem[ptr] each cycle, both ports ignored, init_busy=1
// RUN   | normal operation, one read and one write accepted per cycle
module ram_sdp_sr_rw_init
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
`ifdef RAM_PARITY_EN
    output logic                  rd_perr,
`endif
    output logic                  init_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
`ifdef RAM_PARITY_EN
    logic                  par_mem [RAM_DEPTH];
    logic                  s1_perr;
`endif

    ram_state_e            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    assign wr_in_range = 32'(wr_addr) < RAM_DEPTH;
    assign rd_in_range = 32'(rd_addr) < RAM_DEPTH;
    assign wr_acc      = (state == RUN) && cs && wr_en;
    assign rd_acc      = (state == RUN) && cs && rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            ptr       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Array has no reset; only the sweep clears it. Any write on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[ptr] <= '0;
`ifdef RAM_PARITY_EN
                par_mem[ptr] <= 1'b0;
`endif
            end else if (wr_acc && wr_in_range) begin
                mem[wr_addr] <= wr_data;
`ifdef RAM_PARITY_EN
                par_mem[wr_addr] <= parity_f(PARITY_MAX_W'(wr_data));
`endif
            end
        end
    end

    // First read register samples the array before this edge's write lands: read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
`ifdef RAM_PARITY_EN
            s1_perr  <= 1'b0;
`endif
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_in_range ? mem[rd_addr] : '0;
            end
`ifdef RAM_PARITY_EN
            s1_perr <= rd_acc && rd_in_range &&
                       (par_mem[rd_addr] != parity_f(PARITY_MAX_W'(mem[rd_addr])));
`endif
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_data  (s1_data),
        .in_valid (s1_valid),
`ifdef RAM_PARITY_EN
        .in_perr  (s1_perr),
        .out_perr (rd_perr),
`endif
        .out_data (rd_data),
        .out_valid(rd_valid)
    );

endmodule

// File: doc/ram_sdp_sr_rw_init.md
Name: ram_sdp_sr_rw_init

Overview:
- Parametrised simple dual-port RAM: one write port and one read port, both synchronous on one clock, with a configurable read pipeline.
- Successor to the single-port RAM. Adds concurrent read/write, a read-valid output, and a hardware clear of all words after reset.
- Used as the LDPC decoder's message/LLR storage, where the check and variable node stages read and write in the same cycle.

Parameters:
- DATA_WIDTH, 8, word width in bits (>=1).
- ADDR_WIDTH, 8, address width.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of words (2..2**ADDR_WIDTH).
- READ_LATENCY, 1, cycles from accepted rd_en to rd_valid; legal values are 1 or 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  chip select; gates both ports.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data; holds its last value when rd_valid=0.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.
- init_busy  output  1  high while the clear sweep runs; both ports are ignored.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: rd_data=0, rd_valid=0, init_busy=1, state=INIT, clear pointer=0, read pipeline flushed. Reset does not itself touch array contents.
- FSM states are INIT and RUN.
- INIT behaviour:
  - On each clk edge with rst=0, write 0 to mem[ptr], then ptr++.
  - When ptr==RAM_DEPTH-1, perform that write and go to RUN on the same edge.
  - init_busy falls exactly RAM_DEPTH edges after the first edge with rst=0.
- INIT restrictions:
  - wr_en and rd_en are ignored regardless of cs.
  - rd_valid stays 0.
- RUN state is held until rst.
- Write accept (RUN only): cs & wr_en. mem[wr_addr] <= wr_data at that edge.
- Read accept (RUN only): cs & rd_en.
  - The array is sampled at the accepting edge.
  - READ_LATENCY=1: rd_data/rd_valid are updated at the accepting edge and visible the following cycle.
  - READ_LATENCY=2: one extra output register stage, so results appear one cycle later. rd_valid is pipelined alongside the data.
- Throughput is one read and one write per cycle, continuously, with no bubbles.
- Read-during-write to the same address is read-first: rd_data returns the old contents, and the new value is visible to reads accepted on later edges.
- cs=0 or rd_en=0: no read. rd_valid=0 in the corresponding output cycle, and rd_data holds its value.
- Out-of-range addresses (>=RAM_DEPTH when RAM_DEPTH<2**ADDR_WIDTH):
  - Writes are dropped.
  - Reads return 0 with rd_valid=1.
- rst asserted mid-RUN or mid-INIT:
  - Pipeline flushed, so reads in flight produce no rd_valid.
  - FSM restarts INIT at ptr=0.
  - Writes on the reset edge are dropped.
- No combinational path from any input to any output.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from wr_data (0 for cleared words).
  - Added output port rd_perr (1 bit), aligned with rd_valid. It is 1 when the stored parity mismatches the recomputed parity of the read data; otherwise 0.
  - Reset value of rd_perr is 0.
  - Out-of-range reads give rd_perr=0.
- Not defined: no parity storage and no rd_perr port. The array is exactly DATA_WIDTH bits wide.

Decomposition:
- Package ram_pkg:
  - ram_state_e enum {INIT, RUN}.
  - Localparam constants for legal READ_LATENCY values.
  - Function parity_f(data) returning the XOR reduction.
- Sub-module ram_rd_pipe: parametrised by DATA_WIDTH and READ_LATENCY. Carries data, valid and (if enabled) perr through 0 or 1 extra register stages, with synchronous flush on rst.
- Top module holds the array, FSM, clear pointer and port gating.

Test Plan (bench uses DATA_WIDTH=8, ADDR_WIDTH=4, RAM_DEPTH=16):
- Clear sweep:
  - Stimulus: pulse rst for 2 cycles, then release; cs=1, rd_en=1 throughout.
  - Required: init_busy high for exactly 16 cycles after release, rd_valid=0 throughout. After init, reads of addresses 0..15 return 0x00.
- Basic R/W, READ_LATENCY=1:
  - Stimulus: write 0xA5@3, then read @3.
  - Required: rd_data=0xA5 with rd_valid=1, one cycle after the read is accepted.
- Same-address collision:
  - Stimulus: mem[7]=0x11, then write 0x22@7 and read @7 on the same edge.
  - Required: returns 0x11. A read on the next cycle returns 0x22.
- READ_LATENCY=2 streaming:
  - Stimulus: back-to-back reads of addresses 0..15 holding 0x10+i.
  - Required: 16 consecutive rd_valid pulses, starting 2 cycles after the first accepted read, with data 0x10..0x1F in order.
- Reset mid-stream:
  - Stimulus: assert rst while 2 reads are in flight.
  - Required: no rd_valid for those reads, init restarts, and all words read 0x00 afterwards.
- Parity (RAM_PARITY_EN defined):
  - Stimulus: write 0x07@2, force-flip a data bit of mem[2] in the bench, then read @2.
  - Required: rd_perr=1. An unflipped word gives rd_perr=0.
